// File: rtl/bsg_cgol_result_collector.sv
// Collects CGoL engine rows, forwards each as a tagged payload and appends
// one summary payload (live cells, nonzero rows, first nonzero row) per board.
module bsg_cgol_result_collector #(
  parameter int board_width_p = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        v_i,
  input  logic [63:0] data_i,
  output logic        yumi_o,
  output logic        v_o,
  output logic [74:0] data_o,
  input  logic        ready_i
);

  typedef enum logic {
    ROWS,
    SUMMARY
  } state_e;

  localparam logic [63:0] row_mask_lp = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - board_width_p);
  localparam logic [6:0]  last_row_lp = 7'(board_width_p - 1);

  state_e      state_q, state_d;
  logic        v_q, v_d;
  logic [74:0] data_q, data_d;
  logic [6:0]  row_cnt_q, row_cnt_d;
  logic [12:0] total_q, total_d;
  logic [6:0]  nz_rows_q, nz_rows_d;
  logic        first_seen_q, first_seen_d;
  logic [6:0]  first_nz_q, first_nz_d;

  logic [63:0] row_m;
  logic [6:0]  pop;
  logic        slot_free;
  logic        accept;
  logic        summary_load;
  logic [15:0] first_field;

  assign row_m = data_i & row_mask_lp;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 64; i++) begin
      pop = pop + {6'd0, row_m[i]};
    end
  end

  // The output register may drain and reload in the same cycle.
  assign slot_free    = ~v_q | ready_i;
  assign accept       = v_i & en_i & slot_free & (state_q == ROWS);
  assign summary_load = en_i & slot_free & (state_q == SUMMARY);
  assign first_field  = first_seen_q ? {9'd0, first_nz_q} : 16'hFFFF;

  assign yumi_o = accept;
  assign v_o    = v_q;
  assign data_o = data_q;

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    data_d       = data_q;
    row_cnt_d    = row_cnt_q;
    total_d      = total_q;
    nz_rows_d    = nz_rows_q;
    first_seen_d = first_seen_q;
    first_nz_d   = first_nz_q;

    if (v_q & ready_i) begin
      v_d = 1'b0;
    end

    if (accept) begin
      v_d     = 1'b1;
      data_d  = {2'b00, 2'b00, row_cnt_q, row_m};
      total_d = total_q + {6'd0, pop};
      if (row_m != 64'd0) begin
        nz_rows_d = nz_rows_q + 7'd1;
        if (!first_seen_q) begin
          first_seen_d = 1'b1;
          first_nz_d   = row_cnt_q;
        end
      end
      if (row_cnt_q == last_row_lp) begin
        row_cnt_d = '0;
        state_d   = SUMMARY;
      end else begin
        row_cnt_d = row_cnt_q + 7'd1;
      end
    end else if (summary_load) begin
      // Summary sees the last row's contribution, which landed one cycle earlier.
      v_d          = 1'b1;
      data_d       = {2'b01, 9'd0, first_field, 9'd0, nz_rows_q, 19'd0, total_q};
      total_d      = '0;
      nz_rows_d    = '0;
      first_seen_d = 1'b0;
      first_nz_d   = '0;
      state_d      = ROWS;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ROWS;
      v_q          <= 1'b0;
      data_q       <= '0;
      row_cnt_q    <= '0;
      total_q      <= '0;
      nz_rows_q    <= '0;
      first_seen_q <= 1'b0;
      first_nz_q   <= '0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      data_q       <= data_d;
      row_cnt_q    <= row_cnt_d;
      total_q      <= total_d;
      nz_rows_q    <= nz_rows_d;
      first_seen_q <= first_seen_d;
      first_nz_q   <= first_nz_d;
    end
  end

endmodule

// File: tb/tb_bsg_cgol_result_collector.sv
// Drives a 64-wide and a 3-wide collector side by side and compares every
// cycle against a board-level reference model.
module tb_bsg_cgol_result_collector;

  localparam int W0 = 64;
  localparam int W1 = 3;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  en_i, v_i, ready_i;
  logic [63:0] data_i [2];
  logic        yumi0, yumi1, v_o0, v_o1;
  logic [74:0] data_o0, data_o1;

  always #5 clk = ~clk;

  bsg_cgol_result_collector #(.board_width_p(W0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i[0]), .v_i(v_i[0]),
    .data_i(data_i[0]), .yumi_o(yumi0), .v_o(v_o0), .data_o(data_o0),
    .ready_i(ready_i[0])
  );

  bsg_cgol_result_collector #(.board_width_p(W1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i[1]), .v_i(v_i[1]),
    .data_i(data_i[1]), .yumi_o(yumi1), .v_o(v_o1), .data_o(data_o1),
    .ready_i(ready_i[1])
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the expected output register plus the rows of the
  // board in progress; the summary is computed from the whole stored board.
  logic        m_v    [2];
  logic [74:0] m_data [2];
  logic [63:0] rows   [2][64];
  int          cnt    [2];
  bit          pend   [2];
  int          mode0, mode1;

  function automatic int widthOf(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic logic [63:0] maskOf(input int w);
    logic [63:0] ones;
    ones = '1;
    if (w == 64) return ones;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [74:0] boardSummary(input int k);
    logic [12:0] tot;
    logic [15:0] nz;
    logic [15:0] first;
    tot   = '0;
    nz    = '0;
    first = 16'hFFFF;
    for (int i = 0; i < widthOf(k); i++) begin
      tot = tot + 13'($countones(rows[k][i]));
      if (rows[k][i] != 64'd0) begin
        nz = nz + 16'd1;
        if (first == 16'hFFFF) first = 16'(i);
      end
    end
    return {2'b01, 9'd0, first, nz, 19'd0, tot};
  endfunction

  function automatic logic [63:0] pickData(input int mode, input int idx);
    logic [63:0] r;
    case (mode)
      0: r = 64'h1;
      1: r = 64'h0;
      2: r = (idx == 10) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      4: r = 64'hFF;
      default: begin
        r = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) r = 64'h0;
        else if ($urandom_range(0, 3) == 0) r = 64'h1 << $urandom_range(0, 63);
      end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [74:0] got, input logic [74:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    logic       ey   [2];
    logic       slot;
    logic [63:0] row;
    for (int k = 0; k < 2; k++) begin
      ey[k] = v_i[k] & en_i[k] & (~m_v[k] | ready_i[k]) & ~pend[k];
    end
    @(negedge clk);
    checkOutput("yumi0", 75'(yumi0), 75'(ey[0]));
    checkOutput("yumi1", 75'(yumi1), 75'(ey[1]));
    checkOutput("v_o0", 75'(v_o0), 75'(m_v[0]));
    checkOutput("v_o1", 75'(v_o1), 75'(m_v[1]));
    checkOutput("data_o0", data_o0, m_data[0]);
    checkOutput("data_o1", data_o1, m_data[1]);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset_i) begin
        m_v[k] = 1'b0; m_data[k] = '0; cnt[k] = 0; pend[k] = 1'b0;
      end else begin
        slot = ~m_v[k] | ready_i[k];
        if (m_v[k] & ready_i[k]) m_v[k] = 1'b0;
        if (ey[k]) begin
          row = data_i[k] & maskOf(widthOf(k));
          m_data[k] = {2'b00, 9'(cnt[k]), row};
          m_v[k] = 1'b1;
          rows[k][cnt[k]] = row;
          cnt[k]++;
          if (cnt[k] == widthOf(k)) pend[k] = 1'b1;
        end else if (pend[k] && en_i[k] && slot) begin
          m_data[k] = boardSummary(k);
          m_v[k] = 1'b1;
          pend[k] = 1'b0;
          cnt[k] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      data_i[0] = pickData(mode0, cnt[0]);
      data_i[1] = pickData(mode1, cnt[1]);
      applyStimulus();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0; m_data[k] = '0; cnt[k] = 0; pend[k] = 1'b0;
    end
    reset_i = 1'b1;
    en_i = 2'b11; v_i = 2'b00; ready_i = 2'b11;
    mode0 = 0; mode1 = 4;
    data_i[0] = '0; data_i[1] = '0;
    #1;
    runCycles(2);
    reset_i = 1'b0;
    runCycles(1);

    $display("[TB] board of single-bit rows");
    v_i = 2'b11; mode0 = 0;
    runCycles(65);
    v_i[0] = 1'b0; runCycles(2);

    $display("[TB] all-zero board");
    v_i[0] = 1'b1; mode0 = 1;
    runCycles(65);
    v_i[0] = 1'b0; runCycles(2);

    $display("[TB] single full row at index 10, then a random board");
    v_i[0] = 1'b1; mode0 = 2;
    runCycles(65);
    mode0 = 3;
    runCycles(65);
    v_i[0] = 1'b0; runCycles(2);

    $display("[TB] backpressure hold and release");
    v_i = 2'b11; ready_i = 2'b00;
    runCycles(5);
    ready_i = 2'b11;
    runCycles(20);

    $display("[TB] reset mid-board, enable toggled low");
    reset_i = 1'b1;
    runCycles(1);
    reset_i = 1'b0;
    runCycles(20);
    en_i = 2'b00;
    runCycles(5);
    en_i = 2'b11;
    runCycles(70);

    $display("[TB] randomized traffic");
    mode1 = 3;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        v_i[k]     = ($urandom_range(0, 3) != 0);
        en_i[k]    = ($urandom_range(0, 7) != 0);
        ready_i[k] = ($urandom_range(0, 3) != 0);
      end
      reset_i = ($urandom_range(0, 299) == 0);
      runCycles(1);
    end
    reset_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_cgol_result_collector.md
Name: bsg_cgol_result_collector

Overview:
- Downstream consumer of the CGoL engine's 64-bit result stream, placed between the engine output and the test-node client's ring output.
- Forwards each board row as a tagged 75-bit payload.
- After the last row of a board, appends one summary payload: total live cells, nonzero-row count and first nonzero row index.
- The client node prepends its 4-bit id to form the ring packet.

Parameters:
- board_width_p, 64, rows per board and valid bits per row; legal range 1..64.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- en_i  in  1  node enable; gates input acceptance and summary generation only.
- v_i  in  1  engine row valid.
- data_i  in  64  engine row; only bits [board_width_p-1:0] are meaningful.
- yumi_o  out  1  row consumed this cycle (helpful consumer; depends on v_i).
- v_o  out  1  payload valid.
- data_o  out  75  payload.
- ready_i  in  1  ring side ready; transfer when v_o & ready_i.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (reset_i); all state updates on the rising edge of clk_i.
- Reset values: v_o=0, data_o=0, state=ROWS, row_cnt=0, total=0, nz_rows=0, first_seen=0, first_nz=0.
- yumi_o after reset follows its combinational equation.
- Output is a single register (v_r, data_r); v_o=v_r, data_o=data_r.
- slot_free = ~v_r | ready_i, so a drain and a load may occur in the same cycle and give full throughput.
- Masking: row_m = data_i & mask, where mask has ones in [board_width_p-1:0]. pop = popcount(row_m), 7 bits.
- yumi_o = v_i & en_i & slot_free & (state==ROWS).
- Row packet, loaded when yumi_o=1:
  - [74:73]=2'b00
  - [72:64]=row_cnt, zero-extended to 9 bits
  - [63:0]=row_m
  - Latency: data_i to v_o is 1 cycle.
- Accumulation on accept:
  - total += pop; total width is 13 bits (max 4096).
  - If row_m != 0: nz_rows += 1.
  - If row_m != 0 and first_seen==0: first_nz=row_cnt and first_seen=1.
  - row_cnt += 1.
- State ROWS: on accept with row_cnt==board_width_p-1, row_cnt wraps to 0 and state goes to SUMMARY. The last row packet is still loaded that cycle.
- State SUMMARY:
  - yumi_o=0.
  - When en_i & slot_free, load the summary packet, then clear total, nz_rows, first_seen and first_nz, and go to ROWS.
  - Summary packet: [74:73]=2'b01, [72:64]=0, [63:48]=first_seen ? first_nz zero-extended : 16'hFFFF, [47:32]=nz_rows zero-extended, [31:0]=total zero-extended.
- Accumulator cycle ordering: the summary captures accumulators including the last row, which updates them one cycle earlier. Clearing happens in the same cycle the summary loads.
- en_i=0:
  - No accept and no summary load.
  - A held v_o remains valid and may still drain on ready_i.
  - Accumulators are held.
- Backpressure: while v_r & ~ready_i, data_o holds stable and yumi_o=0.
- board_width_p=1: every accepted row is the last row, so each row is followed by a summary.
- Reset mid-board or mid-summary: all state clears on the next edge. A pending output is dropped (v_o=0). The next accepted row is row 0.
- Type codes 2'b10 and 2'b11 are never emitted.

Test Plan:
1. board_width_p=64, ready_i=1, en_i=1; 64 rows data_i=64'h1 -> 64 row packets with idx 0..63 on consecutive cycles, then summary total=64, nz_rows=64, first_nz=0.
2. All-zero board -> 64 row packets of 0, then summary [63:48]=16'hFFFF, nz_rows=0, total=0.
3. Rows 0..9 zero, row 10=64'hFFFF_FFFF_FFFF_FFFF, rest zero -> summary first_nz=10, nz_rows=1, total=64; a second board then starts from cleared accumulators.
4. Hold ready_i=0 for 5 cycles with v_i=1 -> yumi_o=0, data_o stable. Release -> one transfer per cycle, no row lost or duplicated.
5. board_width_p=3, data_i=64'hFF -> rows carry 64'h7 (masked); summary total=9, nz_rows=3.
6. Assert reset_i after 20 rows; toggle en_i low mid-board -> v_o=0 after reset, next row idx=0, no acceptance while en_i=0, and the summary reflects only post-reset rows.
